// File: rtl/vehicle_status_monitor.sv
// Vehicle status monitor: debounced CPU overheat flag, trip arrival flag and low-fuel flag.
// Optional macro VSM_FUEL_FILTER_EN enables an 8-cycle filter on the low-fuel flag.
//
// state    | meaning
// COOL     | not overheated, no hot samples pending
// HEATING  | not overheated, counting consecutive samples >= HOT_ON
// HOT      | overheated, no cool samples pending
// COOLING  | overheated, counting consecutive samples <= HOT_OFF
module vehicle_status_monitor #(
  parameter logic [7:0] HOT_ON   = 8'd90,
  parameter logic [7:0] HOT_OFF  = 8'd80,
  parameter int         DEBOUNCE = 4,
  parameter logic [7:0] FUEL_LOW = 8'd10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  temp,
  input  logic        temp_valid,
  input  logic        dist_pulse,
  input  logic        load_target,
  input  logic [11:0] target_dist,
  input  logic [7:0]  fuel_level,
  output logic        cpu_overheated,
  output logic        arrived,
  output logic        gas_tank_empty
);

  localparam logic [1:0] COOL    = 2'd0;
  localparam logic [1:0] HEATING = 2'd1;
  localparam logic [1:0] HOT     = 2'd2;
  localparam logic [1:0] COOLING = 2'd3;

  localparam logic [3:0] DEB_CNT = 4'(DEBOUNCE);

  logic [1:0]  state, state_nxt;
  logic [3:0]  run_cnt, cnt_nxt, cnt_inc;
  logic [11:0] dist_cnt, target_reg;
  logic        fuel_low;

  assign cnt_inc = run_cnt + 4'd1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = run_cnt;
    if (temp_valid) begin
      case (state)
        COOL: begin
          if (temp >= HOT_ON) begin
            state_nxt = HEATING;
            cnt_nxt   = 4'd1;
          end else begin
            cnt_nxt = 4'd0;
          end
        end
        HEATING: begin
          if (temp >= HOT_ON) begin
            if (cnt_inc == DEB_CNT) begin
              state_nxt = HOT;
              cnt_nxt   = 4'd0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            state_nxt = COOL;
            cnt_nxt   = 4'd0;
          end
        end
        HOT: begin
          if (temp <= HOT_OFF) begin
            state_nxt = COOLING;
            cnt_nxt   = 4'd1;
          end
        end
        COOLING: begin
          if (temp <= HOT_OFF) begin
            if (cnt_inc == DEB_CNT) begin
              state_nxt = COOL;
              cnt_nxt   = 4'd0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            state_nxt = HOT;
            cnt_nxt   = 4'd0;
          end
        end
        default: begin
          state_nxt = COOL;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= COOL;
      run_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      run_cnt <= cnt_nxt;
    end
  end

  assign cpu_overheated = (state == HOT) || (state == COOLING);

  // Loading a new trip wins over a coincident pulse; the count saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      dist_cnt   <= 12'd0;
      target_reg <= 12'd0;
    end else if (load_target) begin
      dist_cnt   <= 12'd0;
      target_reg <= target_dist;
    end else if (dist_pulse && (dist_cnt != 12'hFFF)) begin
      dist_cnt <= dist_cnt + 12'd1;
    end
  end

  assign arrived = (target_reg != 12'd0) && (dist_cnt >= target_reg);

  assign fuel_low = (fuel_level < FUEL_LOW);

`ifdef VSM_FUEL_FILTER_EN
  logic [2:0] fuel_cnt;

  // Counter reaches 7 after seven low cycles; the eighth low cycle sets the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      fuel_cnt       <= 3'd0;
      gas_tank_empty <= 1'b0;
    end else if (!fuel_low) begin
      fuel_cnt       <= 3'd0;
      gas_tank_empty <= 1'b0;
    end else if (fuel_cnt == 3'd7) begin
      gas_tank_empty <= 1'b1;
    end else begin
      fuel_cnt <= fuel_cnt + 3'd1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      gas_tank_empty <= 1'b0;
    end else begin
      gas_tank_empty <= fuel_low;
    end
  end
`endif

endmodule

// File: tb/tb_vehicle_status_monitor.sv
// Self-checking bench for vehicle_status_monitor: directed scenarios plus randomized
// traffic compared against a streak-counting behavioural model.
module tb_vehicle_status_monitor;

  localparam int HOT_ON   = 90;
  localparam int HOT_OFF  = 80;
  localparam int DEBOUNCE = 4;
  localparam int FUEL_LOW = 10;
  localparam int DIST_MAX = 4095;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  temp;
  logic        temp_valid;
  logic        dist_pulse;
  logic        load_target;
  logic [11:0] target_dist;
  logic [7:0]  fuel_level;
  logic        cpu_overheated;
  logic        arrived;
  logic        gas_tank_empty;

  int errors = 0;
  int checks = 0;

  // Model state: overheat flag with a streak of qualifying samples, trip counters,
  // length of the current run of low-fuel cycles.
  int m_hot, m_streak, m_dist, m_target, m_fuel_run, m_low_q;

  vehicle_status_monitor dut (
    .clk(clk), .reset(reset), .temp(temp), .temp_valid(temp_valid),
    .dist_pulse(dist_pulse), .load_target(load_target), .target_dist(target_dist),
    .fuel_level(fuel_level), .cpu_overheated(cpu_overheated), .arrived(arrived),
    .gas_tank_empty(gas_tank_empty)
  );

  always #5 clk = ~clk;

  function automatic logic exp_hot();
    return (m_hot != 0);
  endfunction

  function automatic logic exp_arrived();
    return (m_target != 0) && (m_dist >= m_target);
  endfunction

  function automatic logic exp_empty();
`ifdef VSM_FUEL_FILTER_EN
    return (m_fuel_run >= 8);
`else
    return (m_low_q != 0);
`endif
  endfunction

  task automatic model_update();
    int qual;
    if (reset) begin
      m_hot = 0; m_streak = 0; m_dist = 0; m_target = 0; m_fuel_run = 0; m_low_q = 0;
    end else begin
      if (temp_valid) begin
        qual = (m_hot != 0) ? (int'(temp) <= HOT_OFF) : (int'(temp) >= HOT_ON);
        if (qual != 0) begin
          m_streak++;
          if (m_streak == DEBOUNCE) begin
            m_hot = (m_hot != 0) ? 0 : 1;
            m_streak = 0;
          end
        end else begin
          m_streak = 0;
        end
      end
      if (load_target) begin
        m_target = int'(target_dist);
        m_dist = 0;
      end else if (dist_pulse && m_dist < DIST_MAX) begin
        m_dist++;
      end
      m_low_q = (int'(fuel_level) < FUEL_LOW);
      m_fuel_run = (m_low_q != 0) ? m_fuel_run + 1 : 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; temp = 8'd0; temp_valid = 1'b0; dist_pulse = 1'b0;
    load_target = 1'b0; target_dist = 12'd0; fuel_level = 8'd50;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({cpu_overheated, arrived, gas_tank_empty} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000", {cpu_overheated, arrived, gas_tank_empty});
    end
  endtask

  task automatic test_overheat_rise();
    do_reset();
    temp_valid = 1'b1; temp = 8'd95;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cpu_overheated !== 1'b0) begin
        errors++;
        $display("FAIL rise_early cycle %0d: got %b expected 0", i, cpu_overheated);
      end
      tick();
    end
    checks++;
    if (cpu_overheated !== 1'b1) begin
      errors++;
      $display("FAIL rise_fifth: got %b expected 1", cpu_overheated);
    end
    temp_valid = 1'b0; temp = 8'd0;
    tick();
    checks++;
    if (cpu_overheated !== 1'b1) begin
      errors++;
      $display("FAIL rise_hold_invalid: got %b expected 1", cpu_overheated);
    end
  endtask

  task automatic test_hysteresis();
    int seq [$];
    // Starts in HOT from the previous task.
    for (int i = 0; i < 20; i++) seq.push_back(85);
    for (int i = 0; i < 3; i++) seq.push_back(75);
    seq.push_back(82);
    for (int i = 0; i < 4; i++) seq.push_back(75);
    temp_valid = 1'b1;
    for (int i = 0; i < seq.size(); i++) begin
      temp = 8'(seq[i]);
      tick();
      checks++;
      if (cpu_overheated !== ((i == seq.size() - 1) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL hysteresis sample %0d temp %0d: got %b expected %b", i, seq[i],
                 cpu_overheated, (i == seq.size() - 1) ? 1'b0 : 1'b1);
      end
    end
    temp_valid = 1'b0;
  endtask

  task automatic test_trip();
    do_reset();
    load_target = 1'b1; target_dist = 12'd3;
    tick();
    load_target = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (arrived !== 1'b0) begin
        errors++;
        $display("FAIL trip_before pulse %0d: got %b expected 0", i, arrived);
      end
      dist_pulse = 1'b1;
      tick();
    end
    dist_pulse = 1'b0;
    checks++;
    if (arrived !== 1'b1) begin
      errors++;
      $display("FAIL trip_arrived: got %b expected 1", arrived);
    end
    tick();
    checks++;
    if (arrived !== 1'b1) begin
      errors++;
      $display("FAIL trip_sticky: got %b expected 1", arrived);
    end
    load_target = 1'b1; target_dist = 12'd1; dist_pulse = 1'b1;
    tick();
    load_target = 1'b0; dist_pulse = 1'b0;
    checks++;
    if (arrived !== 1'b0) begin
      errors++;
      $display("FAIL trip_load_drops_pulse: got %b expected 0", arrived);
    end
    dist_pulse = 1'b1;
    tick();
    dist_pulse = 1'b0;
    checks++;
    if (arrived !== 1'b1) begin
      errors++;
      $display("FAIL trip_after_reload: got %b expected 1", arrived);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    dist_pulse = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      tick();
      checks++;
      if (arrived !== 1'b0) begin
        errors++;
        $display("FAIL sat_no_target pulse %0d: got %b expected 0", i, arrived);
      end
    end
    // With target 4095 a wrapping counter would drop arrived at the end of the run.
    dist_pulse = 1'b0; load_target = 1'b1; target_dist = 12'd4095;
    tick();
    load_target = 1'b0; dist_pulse = 1'b1;
    for (int i = 0; i < 5000; i++) tick();
    dist_pulse = 1'b0;
    checks++;
    if (arrived !== 1'b1 || m_dist != DIST_MAX) begin
      errors++;
      $display("FAIL sat_hold: got %b expected 1 (model count %0d)", arrived, m_dist);
    end
  endtask

  task automatic test_fuel();
    do_reset();
`ifdef VSM_FUEL_FILTER_EN
    fuel_level = 8'd5;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (gas_tank_empty !== 1'b0) begin
        errors++;
        $display("FAIL fuel_seven cycle %0d: got %b expected 0", i, gas_tank_empty);
      end
    end
    fuel_level = 8'd12;
    tick();
    checks++;
    if (gas_tank_empty !== 1'b0) begin
      errors++;
      $display("FAIL fuel_seven_break: got %b expected 0", gas_tank_empty);
    end
    fuel_level = 8'd5;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (gas_tank_empty !== 1'b0) begin
        errors++;
        $display("FAIL fuel_eight_early cycle %0d: got %b expected 0", i, gas_tank_empty);
      end
      tick();
    end
    checks++;
    if (gas_tank_empty !== 1'b1) begin
      errors++;
      $display("FAIL fuel_eight_set: got %b expected 1", gas_tank_empty);
    end
`else
    fuel_level = 8'd5;
    tick();
    checks++;
    if (gas_tank_empty !== 1'b1) begin
      errors++;
      $display("FAIL fuel_direct_set: got %b expected 1", gas_tank_empty);
    end
`endif
    fuel_level = 8'd10;
    tick();
    checks++;
    if (gas_tank_empty !== 1'b0) begin
      errors++;
      $display("FAIL fuel_clear_at_threshold: got %b expected 0", gas_tank_empty);
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    load_target = 1'b1; target_dist = 12'd1;
    tick();
    load_target = 1'b0; dist_pulse = 1'b1; temp_valid = 1'b1; temp = 8'd95;
    for (int i = 0; i < 3; i++) tick();
    dist_pulse = 1'b0;
    checks++;
    if (arrived !== 1'b1 || cpu_overheated !== 1'b0 || m_streak != 3) begin
      errors++;
      $display("FAIL rstp_setup: arrived %b overheated %b expected 1 0", arrived, cpu_overheated);
    end
    reset = 1'b1; dist_pulse = 1'b1; load_target = 1'b1; target_dist = 12'd2; fuel_level = 8'd0;
    tick();
    reset = 1'b0; dist_pulse = 1'b0; load_target = 1'b0; fuel_level = 8'd50;
    checks++;
    if ({cpu_overheated, arrived, gas_tank_empty} !== 3'b000) begin
      errors++;
      $display("FAIL rstp_outputs: got %b expected 000", {cpu_overheated, arrived, gas_tank_empty});
    end
    tick();
    temp_valid = 1'b0;
    checks++;
    if (cpu_overheated !== 1'b0) begin
      errors++;
      $display("FAIL rstp_one_more_sample: got %b expected 0", cpu_overheated);
    end
  endtask

  task automatic test_random();
    do_reset();
    fuel_level = 8'd50;
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 299) == 0);
      temp_valid  = ($urandom_range(0, 3) != 0);
      temp        = 8'($urandom_range(70, 100));
      dist_pulse  = $urandom_range(0, 1) == 1;
      load_target = ($urandom_range(0, 59) == 0);
      target_dist = 12'($urandom_range(0, 40));
      if ($urandom_range(0, 9) == 0) fuel_level = 8'($urandom_range(0, 20));
      tick();
      checks++;
      if (cpu_overheated !== exp_hot() || arrived !== exp_arrived() ||
          gas_tank_empty !== exp_empty()) begin
        errors++;
        $display("FAIL random cycle %0d: got oh/arr/empty %b%b%b expected %b%b%b", i,
                 cpu_overheated, arrived, gas_tank_empty, exp_hot(), exp_arrived(), exp_empty());
      end
    end
  endtask

  initial begin
    m_hot = 0; m_streak = 0; m_dist = 0; m_target = 0; m_fuel_run = 0; m_low_q = 0;
    idle_inputs();
    test_reset();
    test_overheat_rise();
    test_hysteresis();
    test_trip();
    test_saturation();
    test_fuel();
    test_reset_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vehicle_status_monitor.md
VEHICLE_STATUS_MONITOR -- requirements
Module: vehicle_status_monitor

Interface
REQ-001 Parameter HOT_ON, 8'd90, temp at/above which an overheat sample qualifies.
REQ-002 Parameter HOT_OFF, 8'd80, temp at/below which a cool-down sample qualifies; HOT_OFF < HOT_ON.
REQ-003 Parameter DEBOUNCE, 4, consecutive qualifying temp samples needed to change state; legal range 2..15.
REQ-004 Parameter FUEL_LOW, 8'd10, fuel_level strictly below this counts as low.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 temp  input  8  unsigned CPU temperature sample.
REQ-008 temp_valid  input  1  temp is sampled only in cycles where this is 1.
REQ-009 dist_pulse  input  1  one-cycle pulse per distance unit travelled.
REQ-010 load_target  input  1  loads target_dist and clears distance count.
REQ-011 target_dist  input  12  trip length in distance units.
REQ-012 fuel_level  input  8  unsigned fuel gauge reading.
REQ-013 cpu_overheated  output  1  debounced overheat flag, feeds downstream shut-off logic.
REQ-014 arrived  output  1  trip target reached, feeds downstream drive logic.
REQ-015 gas_tank_empty  output  1  filtered low-fuel flag, feeds downstream drive logic.

Function
REQ-016 Temp FSM SHALL have states COOL, HEATING, HOT, COOLING plus a 4-bit run counter; cycles with temp_valid=0 change nothing.
REQ-017 COOL: sample >= HOT_ON -> HEATING, cnt=1; else stay, cnt=0.
REQ-018 HEATING: sample >= HOT_ON -> cnt+1, entering HOT when cnt+1 == DEBOUNCE (cnt=0); sample < HOT_ON -> COOL, cnt=0.
REQ-019 HOT: sample <= HOT_OFF -> COOLING, cnt=1; else stay.
REQ-020 COOLING: sample <= HOT_OFF -> cnt+1, entering COOL when cnt+1 == DEBOUNCE (cnt=0); sample > HOT_OFF -> HOT, cnt=0.
REQ-021 cpu_overheated SHALL be 1 exactly when state is HOT or COOLING, decoded from the state register (high the cycle after the DEBOUNCE-th qualifying sample).
REQ-022 Samples strictly between HOT_OFF and HOT_ON SHALL hold HOT/COOL (COOLING returns to HOT, HEATING returns to COOL).
REQ-023 Distance: 12-bit dist_cnt increments on dist_pulse, saturating at 4095 (no wrap).
REQ-024 load_target=1 SHALL set target_reg=target_dist and dist_cnt=0; a simultaneous dist_pulse is discarded.
REQ-025 arrived SHALL equal (target_reg != 0) && (dist_cnt >= target_reg), decoded from registers; pulse in cycle N -> arrived in N+1.
REQ-026 arrived SHALL stay 1 until the next load_target or reset; target_reg=0 means no trip, arrived=0.
REQ-027 All outputs SHALL be fully assigned every cycle; no latches.

Reset
REQ-028 reset=1 at a rising edge SHALL force state=COOL, run counter=0, dist_cnt=0, target_reg=0, fuel counter=0, all three outputs 0.
REQ-029 reset SHALL take priority over temp_valid, dist_pulse, load_target in the same cycle, including mid-debounce or mid-trip.

Configuration
REQ-030 Macro VSM_FUEL_FILTER_EN defined: 3-bit counter counts consecutive cycles with fuel_level < FUEL_LOW (saturates at 7); gas_tank_empty sets in the cycle after the 8th consecutive low cycle, clears in the cycle after the first cycle with fuel_level >= FUEL_LOW (counter cleared then).
REQ-031 Macro undefined: gas_tank_empty SHALL be a flop of (fuel_level < FUEL_LOW), one-cycle latency, no counter present.

Verification
REQ-032 temp_valid=1, temp=95 for 4 cycles -> cpu_overheated 0 through those cycles, 1 in the 5th cycle.
REQ-033 From HOT: temp=85 for 20 valid samples -> cpu_overheated stays 1; then temp=75 x3, temp=82 x1, temp=75 x4 -> stays 1 until the cycle after the last of the final 4, then 0.
REQ-034 load_target with target_dist=3, then 3 dist_pulses -> arrived 1 the cycle after the 3rd pulse; load_target with a simultaneous pulse -> dist_cnt 0, arrived 0.
REQ-035 target_dist=0, 5000 pulses -> arrived 0, dist_cnt saturated at 4095.
REQ-036 VSM_FUEL_FILTER_EN defined: fuel_level=5 for 7 cycles then 12 -> gas_tank_empty never 1; 5 for 8 cycles -> 1 in the 9th cycle. Undefined: fuel_level=5 -> 1 next cycle.
REQ-037 reset asserted during HEATING (cnt=3) and with arrived=1 -> next cycle all outputs 0; one further temp=95 sample does not assert cpu_overheated.
